// File: rtl/nibble_serial_sub.sv
// Nibble-serial unsigned subtractor: one 4-bit borrow-chain slice per clock, LSB first,
// with valid/ready operand and result handshakes.

module nibble_sub4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_bi,
    output logic [3:0] o_d,
    output logic       o_bo
);

    logic [4:0] w_res;

    // Bit 4 of the 5-bit wrap-around result is set exactly when a - b - bi < 0
    assign w_res = {1'b0, i_a} - {1'b0, i_b} - {4'b0000, i_bi};
    assign o_d   = w_res[3:0];
    assign o_bo  = w_res[4];

endmodule

module nibble_serial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             zero
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic               r_b_out;
    logic               r_zero;
    logic [3:0]         w_d;
    logic               w_bo;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_nxt;

    nibble_sub4 u_sub4 (
        .i_a  (r_a[3:0]),
        .i_b  (r_b[3:0]),
        .i_bi (r_borrow),
        .o_d  (w_d),
        .o_bo (w_bo)
    );

    assign w_last    = (r_state == S_BUSY) && (r_cnt == CNT_W'(NIB - 1));
    assign w_acc_nxt = (r_acc >> 4) | (WIDTH'(w_d) << (WIDTH - 4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Partial differences accumulate in r_acc so diff holds its last value while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_b_out  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= b_in;
                        r_cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_acc    <= w_acc_nxt;
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff  <= w_acc_nxt;
                        r_b_out <= w_bo;
                        r_zero  <= (w_acc_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign b_out     = r_b_out;
    assign zero      = r_zero;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub at WIDTH=16, 4 and 32.

module tb_nibble_serial_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_ready = 1'b0;

    logic        iv16 = 1'b0, bi16 = 1'b0, ir16, ov16, bo16, z16;
    logic [15:0] a16 = '0, b16 = '0, d16;
    logic        iv4 = 1'b0, bi4 = 1'b0, ir4, ov4, bo4, z4;
    logic [3:0]  a4 = '0, b4 = '0, d4;
    logic        iv32 = 1'b0, bi32 = 1'b0, ir32, ov32, bo32, z32;
    logic [31:0] a32 = '0, b32 = '0, d32;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nibble_serial_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .b_in(bi16), .out_valid(ov16), .out_ready(out_ready), .diff(d16), .b_out(bo16), .zero(z16)
    );

    nibble_serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .b_in(bi4), .out_valid(ov4), .out_ready(out_ready), .diff(d4), .b_out(bo4), .zero(z4)
    );

    nibble_serial_sub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .b_in(bi32), .out_valid(ov32), .out_ready(out_ready), .diff(d32), .b_out(bo32), .zero(z32)
    );

    function automatic logic ov_of(input int w);
        case (w)
            4:       return ov4;
            32:      return ov32;
            default: return ov16;
        endcase
    endfunction

    // Launch one operation on the selected instance and wait (bounded) for its result
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic bin,
                          output logic [31:0] d, output logic bo, output logic z, output int lat);
        @(posedge clk); #1;
        case (w)
            4:       begin a4 = av[3:0];   b4 = bv[3:0];   bi4 = bin;  iv4 = 1'b1;  end
            32:      begin a32 = av;       b32 = bv;       bi32 = bin; iv32 = 1'b1; end
            default: begin a16 = av[15:0]; b16 = bv[15:0]; bi16 = bin; iv16 = 1'b1; end
        endcase
        @(posedge clk); #1;
        iv4 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
        lat = 0;
        while (!ov_of(w) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        case (w)
            4:       begin d = {28'd0, d4};  bo = bo4;  z = z4;  end
            32:      begin d = d32;          bo = bo32; z = z32; end
            default: begin d = {16'd0, d16}; bo = bo16; z = z16; end
        endcase
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if (ir16 !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got %b exp 1", ir16); end
        tests++; if (ov16 !== 1'b0)  begin fails++; $display("FAIL reset_out_valid got %b exp 0", ov16); end
        tests++; if (d16 !== 16'h0)  begin fails++; $display("FAIL reset_diff got %h exp 0000", d16); end
        tests++; if (bo16 !== 1'b0)  begin fails++; $display("FAIL reset_b_out got %b exp 0", bo16); end
        tests++; if (z16 !== 1'b0)   begin fails++; $display("FAIL reset_zero got %b exp 0", z16); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] d; logic bo, z; int lat;
        run_op(16, 32'h1234, 32'h0034, 1'b0, d, bo, z, lat);
        tests++; if (lat != 4)        begin fails++; $display("FAIL basic_latency got %0d exp 4", lat); end
        tests++; if (d !== 32'h1200)  begin fails++; $display("FAIL basic_diff got %h exp 1200", d); end
        tests++; if (bo !== 1'b0)     begin fails++; $display("FAIL basic_b_out got %b exp 0", bo); end
        tests++; if (z !== 1'b0)      begin fails++; $display("FAIL basic_zero got %b exp 0", z); end
        release_result();
        tests++; if (ir16 !== 1'b1)   begin fails++; $display("FAIL basic_in_ready_after got %b exp 1", ir16); end
    endtask

    task automatic test_borrow_ripple();
        logic [31:0] d; logic bo, z; int lat;
        run_op(16, 32'h0005, 32'h0006, 1'b0, d, bo, z, lat);
        tests++; if (d !== 32'hFFFF)  begin fails++; $display("FAIL under_diff got %h exp ffff", d); end
        tests++; if (bo !== 1'b1)     begin fails++; $display("FAIL under_b_out got %b exp 1", bo); end
        release_result();
        run_op(16, 32'hA000, 32'h0001, 1'b0, d, bo, z, lat);
        tests++; if (d !== 32'h9FFF)  begin fails++; $display("FAIL ripple_diff got %h exp 9fff", d); end
        tests++; if (bo !== 1'b0)     begin fails++; $display("FAIL ripple_b_out got %b exp 0", bo); end
        release_result();
    endtask

    task automatic test_borrow_in();
        logic [31:0] d; logic bo, z; int lat;
        run_op(16, 32'h0000, 32'h0000, 1'b1, d, bo, z, lat);
        tests++; if (d !== 32'hFFFF)  begin fails++; $display("FAIL bin_eq_diff got %h exp ffff", d); end
        tests++; if (bo !== 1'b1)     begin fails++; $display("FAIL bin_eq_b_out got %b exp 1", bo); end
        tests++; if (z !== 1'b0)      begin fails++; $display("FAIL bin_eq_zero got %b exp 0", z); end
        release_result();
        run_op(16, 32'h00FF, 32'h00FE, 1'b1, d, bo, z, lat);
        tests++; if (d !== 32'h0000)  begin fails++; $display("FAIL bin_zero_diff got %h exp 0000", d); end
        tests++; if (z !== 1'b1)      begin fails++; $display("FAIL bin_zero_zero got %b exp 1", z); end
        tests++; if (bo !== 1'b0)     begin fails++; $display("FAIL bin_zero_b_out got %b exp 0", bo); end
        release_result();
    endtask

    task automatic test_backpressure();
        int n;
        @(posedge clk); #1;
        a16 = 16'h4321; b16 = 16'h0321; bi16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        // Keep offering different operands; they must be ignored until released
        a16 = 16'hFFFF; b16 = 16'h0000; bi16 = 1'b1;
        n = 0;
        while (!ov16 && n < 50) begin
            tests++; if (ir16 !== 1'b0) begin fails++; $display("FAIL bp_busy_in_ready got %b exp 0", ir16); end
            @(posedge clk); #1;
            n++;
        end
        tests++; if (n != 4) begin fails++; $display("FAIL bp_latency got %0d exp 4", n); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (ov16 !== 1'b1 || d16 !== 16'h4000 || bo16 !== 1'b0 || ir16 !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cyc %0d got ov=%b diff=%h bo=%b ir=%b exp ov=1 diff=4000 bo=0 ir=0",
                         i, ov16, d16, bo16, ir16);
            end
            @(posedge clk); #1;
        end
        iv16 = 1'b0;
        release_result();
        tests++; if (ov16 !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid got %b exp 0", ov16); end
        tests++; if (ir16 !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b exp 1", ir16); end
        @(posedge clk); #1;
        tests++; if (ir16 !== 1'b1) begin fails++; $display("FAIL bp_no_phantom_op got in_ready %b exp 1", ir16); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic bo, z; int lat;
        @(posedge clk); #1;
        a16 = 16'h5555; b16 = 16'h1111; bi16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++; if (ir16 !== 1'b1)  begin fails++; $display("FAIL midrst_in_ready got %b exp 1", ir16); end
        tests++; if (ov16 !== 1'b0)  begin fails++; $display("FAIL midrst_out_valid got %b exp 0", ov16); end
        tests++; if (d16 !== 16'h0)  begin fails++; $display("FAIL midrst_diff got %h exp 0000", d16); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16, 32'h0009, 32'h0004, 1'b0, d, bo, z, lat);
        tests++; if (lat != 4)       begin fails++; $display("FAIL midrst_latency got %0d exp 4", lat); end
        tests++; if (d !== 32'h0005) begin fails++; $display("FAIL midrst_diff_after got %h exp 0005", d); end
        tests++; if (bo !== 1'b0)    begin fails++; $display("FAIL midrst_b_out_after got %b exp 0", bo); end
        release_result();
    endtask

    task automatic test_widths();
        logic [31:0] d; logic bo, z; int lat;
        run_op(4, 32'd10, 32'd4, 1'b0, d, bo, z, lat);
        tests++; if (lat != 1)        begin fails++; $display("FAIL w4_latency got %0d exp 1", lat); end
        tests++; if (d !== 32'd6)     begin fails++; $display("FAIL w4_diff got %0d exp 6", d); end
        tests++; if (bo !== 1'b0)     begin fails++; $display("FAIL w4_b_out got %b exp 0", bo); end
        release_result();
        run_op(32, 32'h8000_0000, 32'h0000_0001, 1'b0, d, bo, z, lat);
        tests++; if (lat != 8)            begin fails++; $display("FAIL w32_latency got %0d exp 8", lat); end
        tests++; if (d !== 32'h7FFF_FFFF) begin fails++; $display("FAIL w32_diff got %h exp 7fffffff", d); end
        tests++; if (bo !== 1'b0)         begin fails++; $display("FAIL w32_b_out got %b exp 0", bo); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_ripple();
        test_borrow_in();
        test_backpressure();
        test_reset_mid();
        test_widths();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-word unsigned subtractor that processes operands one 4-bit nibble per clock, LSB first.
- The borrow between nibbles is held in a register.
- It is the sequential control stage that sits directly upstream of, and wraps, the 4-bit borrow-chain subtract datapath. It feeds that datapath one nibble pair plus the registered borrow each cycle and collects the 4-bit difference and borrow-out.
- Operand and result transfers use a valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; NIB = WIDTH/4.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
b_in  input  1  initial borrow into nibble 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  (a - b - b_in) mod 2^WIDTH
b_out  output  1  final borrow; 1 iff a < b + b_in (unsigned)
zero  output  1  diff == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, diff=0, b_out=0, zero=0.
  - Internal operand shift registers, nibble counter and borrow register are cleared.
  - Reset asserted mid-BUSY or in DONE aborts the operation and discards the result; no partial output is presented.
- The state machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1, the block latches a, b, sets borrow to b_in, sets cnt to 0 and moves to BUSY.
  - in_valid=0 leaves the block in IDLE.
- BUSY:
  - in_ready=0. in_valid is ignored and a, b and b_in may change freely.
  - Each cycle computes {bo, d} = a_nib - b_nib - borrow as a 4-bit subtract, taking the current low nibbles of the operand shift registers.
  - d shifts into the MSB end of the result register, both operand registers shift right by 4, borrow takes bo, and cnt increments.
  - When cnt == NIB-1, that cycle's edge moves the block to DONE and loads b_out with the final bo.
- DONE:
  - out_valid=1. diff, b_out and zero are stable and held.
  - zero is computed from the final registered diff.
  - When out_ready=1 at a clock edge, the block returns to IDLE. in_ready rises the following cycle, so there is no same-cycle accept-and-release.
  - When out_ready=0, the block holds indefinitely with no change to any output.
- Latency:
  - Operands accepted at edge k give out_valid=1 after edge k+NIB.
  - Throughput is one operation per NIB+2 cycles minimum.
- Outputs after DONE: diff, b_out and zero keep their last values in IDLE and BUSY, but are only meaningful while out_valid=1.
- Arithmetic:
  - All values are unsigned.
  - Borrow ripples across every nibble boundary. For example, 0x1000 - 1 requires a borrow through three nibbles.
  - b_in=1 with a==b gives diff all-ones and b_out=1.
- out_ready asserted outside DONE has no effect.
- All outputs are driven from registers; there are no combinational input-to-output paths except none. in_ready and out_valid are decoded from the state register.

Test Plan:
- Reset, then a=0x1234, b=0x0034, b_in=0, in_valid pulse -> out_valid rises exactly 4 cycles after acceptance; diff=0x1200, b_out=0, zero=0.
- a=0x0005, b=0x0006, b_in=0 -> diff=0xFFFF, b_out=1. Then a=0xA000, b=0x0001 -> diff=0x9FFF, b_out=0 (borrow ripples through 3 nibbles).
- a=0x0000, b=0x0000, b_in=1 -> diff=0xFFFF, b_out=1. Then a=0x00FF, b=0x00FE, b_in=1 -> diff=0x0000, zero=1, b_out=0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, diff and b_out stable and in_ready=0. in_valid pulsed with new operands during BUSY/DONE is ignored. out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
- Reset mid-operation: accept a=0x5555, b=0x1111, drop rst_n after 2 BUSY cycles -> immediately in_ready=1, out_valid=0, diff=0. Then a=0x0009, b=0x0004 completes normally with diff=0x0005.
- Parameter sweep: WIDTH=4 with a=10, b=4 -> diff=6, latency 1. WIDTH=32 with a=0x80000000, b=1 -> diff=0x7FFFFFFF, b_out=0, latency 8.
